// File: rtl/moore_110_detector.sv
// rtl/moore_110_detector.sv - Moore FSM that strobes detected for one cycle after the serial pattern 1,1,0
module moore_110_detector (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    output logic detected
);

    typedef enum logic [1:0] {
        S0   = 2'b00,
        S1   = 2'b01,
        S11  = 2'b10,
        S110 = 2'b11
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // The trailing 0 of a match cannot start a new one, so S110 restarts like S0.
    always_comb begin
        state_next = S0;
        case (state)
            S0:      state_next = in_bit ? S1  : S0;
            S1:      state_next = in_bit ? S11 : S0;
            S11:     state_next = in_bit ? S11 : S110;
            S110:    state_next = in_bit ? S1  : S0;
            default: state_next = S0;
        endcase
    end

    assign detected = (state == S110);

endmodule

// File: tb/tb_moore_110_detector.sv
// tb/tb_moore_110_detector.sv - table-driven directed bench for moore_110_detector
module tb_moore_110_detector;

    logic clk;
    logic rst;
    logic in_bit;
    logic detected;

    int checks;
    int errors;

    typedef struct {
        logic rst;
        logic in_bit;
        logic exp;
    } vec_t;

    vec_t vecs[$];

    moore_110_detector dut (
        .clk      (clk),
        .rst      (rst),
        .in_bit   (in_bit),
        .detected (detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic b, input logic exp, input string name);
        @(negedge clk);
        rst    = r;
        in_bit = b;
        @(posedge clk);
        #1;
        checks++;
        if (detected !== exp) begin
            errors++;
            $display("FAIL %s: detected=%b expected=%b", name, detected, exp);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic exp);
        vec_t v;
        v.rst    = r;
        v.in_bit = b;
        v.exp    = exp;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        in_bit = 1'b1;

        // reset with in_bit=1, then release
        add(1, 1, 0); add(0, 0, 0);
        // basic match, then a 1 moves to S1
        add(0, 1, 0); add(0, 1, 0); add(0, 0, 1); add(0, 1, 0);
        // repeated match from a clean start
        add(1, 0, 0);
        add(0, 1, 0); add(0, 1, 0); add(0, 0, 1);
        add(0, 1, 0); add(0, 1, 0); add(0, 0, 1);
        // long run of ones gives one pulse
        add(0, 1, 0); add(0, 1, 0); add(0, 1, 0); add(0, 1, 0); add(0, 0, 1);
        // alternating 1,0 never matches
        add(0, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 0, 0);
        // mid-sequence reset discards the 1,1 prefix
        add(0, 1, 0); add(0, 1, 0); add(1, 0, 0); add(0, 0, 0);
        add(0, 1, 0); add(0, 1, 0); add(0, 0, 1);
        // reset while in the output state cuts the pulse
        add(1, 1, 0);
        add(0, 1, 0); add(0, 1, 0); add(0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].in_bit, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // pulse lasts exactly one cycle: a following 0 clears it
        step(0, 0, 0, "pulse_width");
        step(0, 0, 0, "idle_after_pulse");

        // reset held several edges with in_bit=1 must not build a prefix
        step(0, 1, 0, "pre_hold_1");
        step(1, 1, 0, "hold_rst_0");
        step(1, 1, 0, "hold_rst_1");
        step(1, 1, 0, "hold_rst_2");
        step(0, 0, 0, "after_hold_zero");
        step(0, 1, 0, "after_hold_1a");
        step(0, 0, 0, "single_one_then_zero");

        // reset arriving on the same edge as the terminating 0
        step(0, 1, 0, "rst_on_zero_1a");
        step(0, 1, 0, "rst_on_zero_1b");
        step(1, 0, 0, "rst_on_zero");
        step(0, 0, 0, "rst_on_zero_after");

        // back-to-back matches are three cycles apart
        step(0, 1, 0, "b2b_1");
        step(0, 1, 0, "b2b_2");
        step(0, 0, 1, "b2b_3");
        step(0, 1, 0, "b2b_4");
        step(0, 1, 0, "b2b_5");
        step(0, 0, 1, "b2b_6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
